gsim_param: RTL and testbench
=============================

Name: gsim_param

Overview:
Parametrised Gauss-Seidel solver for the banded system 20·x[i] − 13(x[i−1]+x[i+1]) + 6(x[i−2]+x[i+2]) − (x[i−3]+x[i+3]) = b[i], i = 0..N−1.
- Accepts N right-hand-side samples and iterates in place with the newest values.
- Supports optional half-averaging relaxation and tolerance-based early stop.
- Streams the N solution values out.
- Next-generation replacement for the fixed 16-unknown solver; generalises size, widths, fixed-point format, iteration control and handshake.

Parameters:
N, 16, number of unknowns (1..64)
B_W, 16, signed width of b samples
X_W, 32, signed width of x values
FRAC, 16, fractional bits of x (b is integer, aligned by <<FRAC)
MAX_ITER, 64, maximum sweeps before forced stop (>=1)
TOL, 1, convergence threshold in x LSBs (max |Δx| over a sweep <= TOL stops)
RELAX, 1, 0 = plain update; 1 = x_new = (upd + x_old) >>> 1
IT_W, 7, width of iter_count (must hold MAX_ITER)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
in_en  input  1  b sample valid; accepted only when in_ready=1
b_in  input  B_W  signed b sample, index order 0..N−1
in_ready  output  1  block can accept b samples
out_valid  output  1  x_out holds a valid solution element
x_out  output  X_W  signed solution value, FRAC fractional bits
iter_count  output  IT_W  sweeps executed for the current result, valid with out_valid
converged  output  1  1 = stopped by TOL, 0 = stopped by MAX_ITER; valid with out_valid

Behaviour:
- Reset: when reset=0 at a clock edge, go to IDLE.
  - in_ready=1, out_valid=0, x_out=0, iter_count=0, converged=0.
  - Clear all x storage to 0 and clear all counters.
  - Reset applied during any state aborts the operation; there is no partial output.
- States: IDLE, LOAD, SOLVE, OUT.
- IDLE / LOAD:
  - in_ready=1.
  - Each cycle with in_en=1 stores b_in at index load_cnt and sets x[load_cnt]=0, then increments load_cnt.
  - Gaps in in_en are allowed; state holds.
  - The first accepted sample moves IDLE→LOAD.
  - On the N-th accepted sample, go to SOLVE next cycle with in_ready=0. For N=1, IDLE→SOLVE directly.
- SOLVE: one unknown updated per cycle, index i = 0..N−1 ascending; a sweep is N cycles.
  - Neighbour indices outside 0..N−1 read as 0.
  - Neighbour values are the current register contents, so x[i−k] already holds this sweep's value (true Gauss-Seidel).
  - num = (sext(b[i])<<FRAC) + 13(xm1+xp1) − 6(xm2+xp2) + (xm3+xp3), computed at X_W+6 bits with no overflow.
  - upd = floor(num/20), rounding toward −∞, exact for all inputs. A reciprocal-multiply implementation must match bit-exactly.
  - RELAX=1: x_new = floor((upd + x_old)/2), computed at X_W+1 bits.
  - x_new saturates to the signed X_W range.
  - Write x[i]=x_new; track max |x_new − x_old| over the sweep.
  - At sweep end, increment iter.
    - If maxΔ <= TOL: converged=1, go to OUT.
    - Else if iter == MAX_ITER: converged=0, go to OUT.
    - Else start the next sweep.
  - in_en is ignored in SOLVE and OUT.
- Pipelining is permitted, but the index-ordered dependency must hold (x[i] uses the updated x[i−1]). Total SOLVE latency must be <= 4·N cycles per sweep.
- OUT:
  - out_valid=1 for exactly N consecutive cycles; x_out = x[0], x[1], …, x[N−1].
  - iter_count and converged are held stable throughout.
  - After the last element: out_valid=0, x_out=0, return to IDLE with in_ready=1.
  - The next b sample may be accepted on the cycle after the last output.
- Whenever out_valid=0, x_out=0.

Test Plan:
- N=1, FRAC=0, RELAX=0, TOL=0, b=41 → sweep1 x=2 (Δ=2), sweep2 Δ=0 → one out_valid cycle, x_out=2, iter_count=2, converged=1.
- N=1, FRAC=0, RELAX=0, TOL=0, b=−41 → x_out=−3 (floor), iter_count=2, converged=1. Same with RELAX=1, b=41 → x_out=1, iter_count=2.
- Defaults, all 16 b=0 → 16 out_valid cycles all x_out=0, iter_count=1, converged=1; in_ready=0 from the cycle after the 16th load until the cycle after the last output.
- Defaults, b[i]=i·100 with random in_en gaps, MAX_ITER=1 → iter_count=1, converged=0, x_out matches the bit-exact reference model of one sweep.
- Defaults, b[i]=1000 for all i → converged=1, iter_count < 64, every x_out equals the reference model.
- Assert reset=0 mid-SOLVE → next cycle in_ready=1, out_valid=0, x_out=0; a fresh load of b=0 then yields all-zero output with iter_count=1. Pulses of in_en during SOLVE and OUT do not alter results.

Source files
------------

// File: rtl/gsim_param.sv
// Parametrised Gauss-Seidel solver for the banded 7-point system
// 20x[i] - 13(x[i-1]+x[i+1]) + 6(x[i-2]+x[i+2]) - (x[i-3]+x[i+3]) = b[i].
module gsim_param #(
  parameter int N        = 16,
  parameter int B_W      = 16,
  parameter int X_W      = 32,
  parameter int FRAC     = 16,
  parameter int MAX_ITER = 64,
  parameter int TOL      = 1,
  parameter int RELAX    = 1,
  parameter int IT_W     = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_en,
  input  logic signed [B_W-1:0] b_in,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic signed [X_W-1:0] x_out,
  output logic [IT_W-1:0]       iter_count,
  output logic                  converged
);

  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int NW  = X_W + 6;
  localparam int NW1 = NW + 1;
  localparam int DW  = X_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SOLVE = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [CW-1:0]         LAST  = CW'(N - 1);
  localparam logic [IT_W-1:0]       MAX_V = IT_W'(MAX_ITER);
  localparam logic [DW-1:0]         TOL_V = DW'(TOL);
  localparam logic signed [NW1-1:0] XMAX  = {{(NW1-X_W+1){1'b0}}, {(X_W-1){1'b1}}};
  localparam logic signed [NW1-1:0] XMIN  = ~XMAX;

  logic [1:0]            state;
  logic [CW-1:0]         load_cnt, idx, out_cnt;
  logic [IT_W-1:0]       iter, iter_n;
  logic                  conv;
  logic [DW-1:0]         max_d, dabs, sweep_max;
  logic                  tol_hit;
  logic signed [B_W-1:0] b_mem [N];
  logic signed [X_W-1:0] x_mem [N];

  logic signed [B_W-1:0] b_cur;
  logic signed [X_W-1:0] x_old, x_rd, xm1, xm2, xm3, xp1, xp2, xp3, x_new;
  logic signed [NW-1:0]  b_sh, s1, s2, s3, num, q, r, upd;
  logic signed [NW1-1:0] sum1, cand;
  logic signed [DW-1:0]  dlt;

  // Neighbours outside 0..N-1 read as zero; muxes avoid out-of-range indexing.
  always_comb begin
    b_cur = '0;
    x_old = '0;
    x_rd  = '0;
    xm1   = '0;
    xm2   = '0;
    xm3   = '0;
    xp1   = '0;
    xp2   = '0;
    xp3   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (k == 32'(idx)) begin
        b_cur = b_mem[k];
        x_old = x_mem[k];
      end
      if (k + 1 == 32'(idx)) xm1 = x_mem[k];
      if (k + 2 == 32'(idx)) xm2 = x_mem[k];
      if (k + 3 == 32'(idx)) xm3 = x_mem[k];
      if (k == 32'(idx) + 1) xp1 = x_mem[k];
      if (k == 32'(idx) + 2) xp2 = x_mem[k];
      if (k == 32'(idx) + 3) xp3 = x_mem[k];
      if (k == 32'(out_cnt)) x_rd = x_mem[k];
    end
  end

  always_comb begin
    b_sh = NW'(b_cur) <<< FRAC;
    s1   = NW'(xm1) + NW'(xp1);
    s2   = NW'(xm2) + NW'(xp2);
    s3   = NW'(xm3) + NW'(xp3);
    num  = b_sh + NW'(13) * s1 - NW'(6) * s2 + s3;
    // Signed '/' truncates toward zero; step down for negative inexact quotients.
    q    = num / NW'(20);
    r    = num % NW'(20);
    upd  = (r != '0 && num[NW-1]) ? q - NW'(1) : q;
    sum1 = NW1'(upd) + NW1'(x_old);
    cand = (RELAX != 0) ? (sum1 >>> 1) : NW1'(upd);
    if (cand > XMAX)      x_new = XMAX[X_W-1:0];
    else if (cand < XMIN) x_new = XMIN[X_W-1:0];
    else                  x_new = cand[X_W-1:0];
    dlt       = DW'(x_new) - DW'(x_old);
    dabs      = dlt[DW-1] ? $unsigned(-dlt) : $unsigned(dlt);
    sweep_max = (dabs > max_d) ? dabs : max_d;
    tol_hit   = (sweep_max <= TOL_V);
    iter_n    = iter + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      load_cnt <= '0;
      idx      <= '0;
      out_cnt  <= '0;
      iter     <= '0;
      conv     <= 1'b0;
      max_d    <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        x_mem[k] <= '0;
        b_mem[k] <= '0;
      end
    end else begin
      case (state)
        S_IDLE, S_LOAD: begin
          if (in_en) begin
            for (int unsigned k = 0; k < N; k++) begin
              if (k == 32'(load_cnt)) begin
                b_mem[k] <= b_in;
                x_mem[k] <= '0;
              end
            end
            if (load_cnt == LAST) begin
              load_cnt <= '0;
              idx      <= '0;
              iter     <= '0;
              max_d    <= '0;
              state    <= S_SOLVE;
            end else begin
              load_cnt <= load_cnt + 1'b1;
              state    <= S_LOAD;
            end
          end
        end
        S_SOLVE: begin
          for (int unsigned k = 0; k < N; k++) begin
            if (k == 32'(idx)) x_mem[k] <= x_new;
          end
          if (idx == LAST) begin
            idx   <= '0;
            max_d <= '0;
            iter  <= iter_n;
            if (tol_hit) begin
              conv    <= 1'b1;
              out_cnt <= '0;
              state   <= S_OUT;
            end else if (iter_n == MAX_V) begin
              conv    <= 1'b0;
              out_cnt <= '0;
              state   <= S_OUT;
            end
          end else begin
            idx   <= idx + 1'b1;
            max_d <= sweep_max;
          end
        end
        S_OUT: begin
          if (out_cnt == LAST) begin
            out_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            out_cnt <= out_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (state == S_IDLE) || (state == S_LOAD);
  assign out_valid  = (state == S_OUT);
  assign x_out      = out_valid ? x_rd : '0;
  assign iter_count = iter;
  assign converged  = conv;

endmodule

// File: tb/tb_gsim_param.sv
// Self-checking bench for gsim_param: N=1 corner cases and 16-unknown runs
// compared against a longint Gauss-Seidel reference model.
module tb_gsim_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // N=1, FRAC=0, TOL=0: a plain update, b relaxed
  logic               in_en_a, in_en_b;
  logic signed [15:0] b_in_a, b_in_b;
  logic               in_ready_a, in_ready_b, out_valid_a, out_valid_b, conv_a, conv_b;
  logic signed [31:0] x_out_a, x_out_b;
  logic [6:0]         iter_a, iter_b;

  // defaults (c) and defaults with MAX_ITER=1 (d), driven through a shared mux
  logic               en, sel_d;
  logic signed [15:0] b_drv;
  logic               in_ready_c, in_ready_d, out_valid_c, out_valid_d, conv_c, conv_d;
  logic signed [31:0] x_out_c, x_out_d;
  logic [6:0]         iter_c, iter_d;
  logic               mov, mrdy, mconv;
  logic signed [31:0] mx;
  logic [6:0]         mit;

  int tests_run = 0;
  int tests_failed = 0;

  longint ref_b [16];
  longint ref_x [16];
  int     ref_iter;
  bit     ref_conv;

  gsim_param #(.N(1), .FRAC(0), .RELAX(0), .TOL(0)) dut_a (
    .clk(clk), .reset(reset), .in_en(in_en_a), .b_in(b_in_a), .in_ready(in_ready_a),
    .out_valid(out_valid_a), .x_out(x_out_a), .iter_count(iter_a), .converged(conv_a));

  gsim_param #(.N(1), .FRAC(0), .RELAX(1), .TOL(0)) dut_b (
    .clk(clk), .reset(reset), .in_en(in_en_b), .b_in(b_in_b), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .x_out(x_out_b), .iter_count(iter_b), .converged(conv_b));

  gsim_param dut_c (
    .clk(clk), .reset(reset), .in_en(en & ~sel_d), .b_in(b_drv), .in_ready(in_ready_c),
    .out_valid(out_valid_c), .x_out(x_out_c), .iter_count(iter_c), .converged(conv_c));

  gsim_param #(.MAX_ITER(1)) dut_d (
    .clk(clk), .reset(reset), .in_en(en & sel_d), .b_in(b_drv), .in_ready(in_ready_d),
    .out_valid(out_valid_d), .x_out(x_out_d), .iter_count(iter_d), .converged(conv_d));

  always_comb begin
    mov   = sel_d ? out_valid_d : out_valid_c;
    mrdy  = sel_d ? in_ready_d  : in_ready_c;
    mx    = sel_d ? x_out_d     : x_out_c;
    mit   = sel_d ? iter_d      : iter_c;
    mconv = sel_d ? conv_d      : conv_c;
  end

  function automatic longint fdiv(longint a, longint d);
    longint q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint getx(int j);
    if (j < 0 || j > 15) return 0;
    return ref_x[j];
  endfunction

  // Reference: defaults (FRAC=16, RELAX=1, TOL=1, 32-bit saturation).
  task automatic model_solve(input int max_iter);
    longint num, upd, xn, d, maxd;
    for (int i = 0; i < 16; i++) ref_x[i] = 0;
    ref_iter = 0;
    ref_conv = 0;
    for (int it = 0; it < max_iter; it++) begin
      maxd = 0;
      for (int i = 0; i < 16; i++) begin
        num = ref_b[i] * 65536 + 13 * (getx(i-1) + getx(i+1))
              - 6 * (getx(i-2) + getx(i+2)) + (getx(i-3) + getx(i+3));
        upd = fdiv(num, 20);
        xn  = fdiv(upd + ref_x[i], 2);
        if (xn > 64'sd2147483647)  xn = 64'sd2147483647;
        if (xn < -64'sd2147483648) xn = -64'sd2147483648;
        d = (xn > ref_x[i]) ? xn - ref_x[i] : ref_x[i] - xn;
        if (d > maxd) maxd = d;
        ref_x[i] = xn;
      end
      ref_iter = it + 1;
      if (maxd <= 1) begin
        ref_conv = 1;
        break;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load16(input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        en = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      en = 1'b1;
      b_drv = 16'(ref_b[i]);
      tick();
    end
    en = 1'b0;
  endtask

  task automatic collect16(input string name, input bit noise);
    int t = 0;
    while (!mov && t < 2000) begin
      tests_run++;
      if (mrdy !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s_ready_busy: got %0b expected 0", name, mrdy);
      end
      if (noise) begin
        en = 1'($urandom_range(0, 1));
        b_drv = 16'($urandom);
      end
      tick();
      t++;
    end
    tests_run++;
    if (!mov) begin
      tests_failed++;
      $display("FAIL %s_timeout: got out_valid=0 expected 1 within 2000 cycles", name);
      en = 1'b0;
      return;
    end
    for (int k = 0; k < 16; k++) begin
      tests_run++;
      if (mov !== 1'b1 || longint'(mx) != ref_x[k] || mit !== 7'(ref_iter)
          || mconv !== ref_conv || mrdy !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s_x%0d: got v=%0b x=%0d it=%0d cv=%0b rdy=%0b expected v=1 x=%0d it=%0d cv=%0b rdy=0",
                 name, k, mov, mx, mit, mconv, mrdy, ref_x[k], ref_iter, ref_conv);
      end
      if (noise) begin
        en = 1'($urandom_range(0, 1));
        b_drv = 16'($urandom);
      end
      tick();
    end
    en = 1'b0;
    tests_run++;
    if (mov !== 1'b0 || mx !== 32'sd0 || mrdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_after: got v=%0b x=%0d rdy=%0b expected v=0 x=0 rdy=1", name, mov, mx, mrdy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({in_ready_a, in_ready_b, in_ready_c, in_ready_d} !== 4'b1111) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b expected 1111", {in_ready_a, in_ready_b, in_ready_c, in_ready_d});
    end
    tests_run++;
    if ({out_valid_a, out_valid_b, out_valid_c, out_valid_d, conv_a, conv_b, conv_c, conv_d} !== 8'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {out_valid_a, out_valid_b, out_valid_c, out_valid_d, conv_a, conv_b, conv_c, conv_d});
    end
    tests_run++;
    if (x_out_a !== 0 || x_out_b !== 0 || x_out_c !== 0 || x_out_d !== 0 ||
        iter_a !== 0 || iter_b !== 0 || iter_c !== 0 || iter_d !== 0) begin
      tests_failed++;
      $display("FAIL reset_data: got x=%0d/%0d/%0d/%0d it=%0d/%0d/%0d/%0d expected all 0",
               x_out_a, x_out_b, x_out_c, x_out_d, iter_a, iter_b, iter_c, iter_d);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic run_n1(input int ba, input int bb, input bit use_b,
                        input int exp_a, input int exp_b);
    int t = 0;
    in_en_a = 1'b1;
    b_in_a  = 16'(ba);
    in_en_b = use_b;
    b_in_b  = 16'(bb);
    tick();
    in_en_a = 1'b0;
    in_en_b = 1'b0;
    while (!out_valid_a && t < 20) begin
      tick();
      t++;
    end
    tests_run++;
    if (out_valid_a !== 1'b1 || x_out_a !== 32'(exp_a) || iter_a !== 7'd2 || conv_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL n1_plain_b%0d: got v=%0b x=%0d it=%0d cv=%0b expected v=1 x=%0d it=2 cv=1",
               ba, out_valid_a, x_out_a, iter_a, conv_a, exp_a);
    end
    if (use_b) begin
      tests_run++;
      if (out_valid_b !== 1'b1 || x_out_b !== 32'(exp_b) || iter_b !== 7'd2 || conv_b !== 1'b1) begin
        tests_failed++;
        $display("FAIL n1_relax_b%0d: got v=%0b x=%0d it=%0d cv=%0b expected v=1 x=%0d it=2 cv=1",
                 bb, out_valid_b, x_out_b, iter_b, conv_b, exp_b);
      end
    end
    tick();
    tests_run++;
    if (out_valid_a !== 1'b0 || x_out_a !== 32'sd0 || in_ready_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL n1_single_cycle: got v=%0b x=%0d rdy=%0b expected v=0 x=0 rdy=1",
               out_valid_a, x_out_a, in_ready_a);
    end
  endtask

  task automatic test_n1();
    run_n1(41, 41, 1'b1, 2, 1);
    run_n1(-41, 0, 1'b0, -3, 0);
  endtask

  task automatic test_zero();
    sel_d = 1'b0;
    for (int i = 0; i < 16; i++) ref_b[i] = 0;
    model_solve(64);
    load16(1'b0);
    collect16("zero", 1'b0);
  endtask

  task automatic test_max_iter_one();
    sel_d = 1'b1;
    for (int i = 0; i < 16; i++) ref_b[i] = i * 100;
    model_solve(1);
    load16(1'b1);
    collect16("maxit1", 1'b0);
    sel_d = 1'b0;
  endtask

  task automatic test_const();
    sel_d = 1'b0;
    for (int i = 0; i < 16; i++) ref_b[i] = 1000;
    model_solve(64);
    load16(1'b0);
    collect16("const1000", 1'b1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      sel_d = 1'b0;
      for (int i = 0; i < 16; i++) ref_b[i] = longint'(int'($urandom_range(0, 6000)) - 3000);
      model_solve(64);
      load16(1'b1);
      collect16("random", 1'b1);
    end
  endtask

  task automatic test_reset_mid_solve();
    sel_d = 1'b0;
    for (int i = 0; i < 16; i++) ref_b[i] = longint'(int'($urandom_range(500, 3000)));
    load16(1'b0);
    repeat (20) begin
      en = 1'($urandom_range(0, 1));
      b_drv = 16'($urandom);
      tick();
    end
    en = 1'b0;
    tests_run++;
    if (in_ready_c !== 1'b0 || out_valid_c !== 1'b0) begin
      tests_failed++;
      $display("FAIL midsolve_busy: got rdy=%0b v=%0b expected rdy=0 v=0", in_ready_c, out_valid_c);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tests_run++;
    if (in_ready_c !== 1'b1 || out_valid_c !== 1'b0 || x_out_c !== 32'sd0 || iter_c !== 7'd0) begin
      tests_failed++;
      $display("FAIL midsolve_reset: got rdy=%0b v=%0b x=%0d it=%0d expected rdy=1 v=0 x=0 it=0",
               in_ready_c, out_valid_c, x_out_c, iter_c);
    end
    for (int i = 0; i < 16; i++) ref_b[i] = 0;
    model_solve(64);
    load16(1'b0);
    collect16("after_reset", 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before 900000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b0;
    in_en_a = 1'b0;
    in_en_b = 1'b0;
    b_in_a  = '0;
    b_in_b  = '0;
    en      = 1'b0;
    sel_d   = 1'b0;
    b_drv   = '0;
    test_reset();
    test_n1();
    test_zero();
    test_max_iter_one();
    test_const();
    test_random();
    test_reset_mid_solve();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
